// File: rtl/bel_fft_pkg.sv
// Shared widths, rounding constants and complex/twiddle types for the bel_fft datapath.
package bel_fft_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned ADDR_WIDTH = 8;
  localparam int unsigned Q31_FRAC   = 31;
  localparam int unsigned PROD_WIDTH = 2 * DATA_WIDTH;
  localparam int unsigned SUM_WIDTH  = 2 * DATA_WIDTH + 1;

  // Half an LSB of the Q1.31 result, i.e. 1 << (Q31_FRAC - 1).
  localparam logic signed [SUM_WIDTH-1:0] ROUND_CONST =
      {{(SUM_WIDTH - Q31_FRAC){1'b0}}, 1'b1, {(Q31_FRAC - 1){1'b0}}};

  localparam logic signed [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH - 1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH - 1){1'b0}}};

  typedef struct packed {
    logic signed [DATA_WIDTH-1:0] re;
    logic signed [DATA_WIDTH-1:0] im;
  } cplx_t;

  // Field layout of rom_q: upper half cos, lower half -sin.
  typedef struct packed {
    logic signed [DATA_WIDTH-1:0] wr;
    logic signed [DATA_WIDTH-1:0] wi;
  } twiddle_t;

endpackage

// File: rtl/bel_fft_twiddle_mult_if.sv
// Sample stream, twiddle ROM port and result stream of the twiddle-multiply stage.
interface bel_fft_twiddle_mult_if;
  import bel_fft_pkg::*;

  logic                         in_valid;
  logic                         in_ready;
  logic signed [DATA_WIDTH-1:0] in_re;
  logic signed [DATA_WIDTH-1:0] in_im;
  logic [ADDR_WIDTH-1:0]        in_k;

  logic                         rom_clken;
  logic [ADDR_WIDTH-1:0]        rom_address;
  logic [2*DATA_WIDTH-1:0]      rom_q;

  logic                         out_valid;
  logic                         out_ready;
  logic signed [DATA_WIDTH-1:0] out_re;
  logic signed [DATA_WIDTH-1:0] out_im;

  modport slave (
    input  in_valid, in_re, in_im, in_k, rom_q, out_ready,
    output in_ready, rom_clken, rom_address, out_valid, out_re, out_im
  );

  modport master (
    output in_valid, in_re, in_im, in_k, rom_q, out_ready,
    input  in_ready, rom_clken, rom_address, out_valid, out_re, out_im
  );

endinterface

// File: rtl/bel_fft_round_sat.sv
// Round-half-up a Q2.62 sum back to Q1.31 and clamp to the 32-bit signed range.
module bel_fft_round_sat
  import bel_fft_pkg::*;
(
    input  logic signed [SUM_WIDTH-1:0]  sum_i,
    output logic signed [DATA_WIDTH-1:0] res_o
);

    logic signed [SUM_WIDTH-1:0] rounded;
    logic signed [SUM_WIDTH-1:0] shifted;
    logic                        ovf;

    always_comb begin
        rounded = sum_i + ROUND_CONST;
        shifted = rounded >>> Q31_FRAC;
        // Every bit above the result sign bit must equal it, else the value does not fit.
        ovf = (shifted[SUM_WIDTH-1:DATA_WIDTH-1] !=
               {(SUM_WIDTH - DATA_WIDTH + 1){shifted[DATA_WIDTH-1]}});
        if (ovf) begin
            res_o = shifted[SUM_WIDTH-1] ? SAT_MIN : SAT_MAX;
        end else begin
            res_o = shifted[DATA_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/bel_fft_twiddle_mult.sv
// Four-stage valid/ready pipeline multiplying a complex sample by a Q1.31 ROM twiddle.
module bel_fft_twiddle_mult
  import bel_fft_pkg::*;
(
    input logic                   clk_i,
    input logic                   rst_i,
    bel_fft_twiddle_mult_if.slave bus
);

    logic                         adv;
    logic                         v1_q, v2_q, v3_q, v4_q;
    cplx_t                        s1_q, s2_q, out_q;
    twiddle_t                     tw2_q;
    logic signed [PROD_WIDTH-1:0] p_awr_q, p_bwi_q, p_awi_q, p_bwr_q;
    logic signed [PROD_WIDTH-1:0] p_awr_d, p_bwi_d, p_awi_d, p_bwr_d;
    logic signed [DATA_WIDTH-1:0] a, b, wr, wi;
    logic signed [SUM_WIDTH-1:0]  sum_re, sum_im;
    logic signed [DATA_WIDTH-1:0] res_re, res_im;

    // The whole pipe moves together unless a finished result is being held.
    always_comb begin
        adv = ~(v4_q & ~bus.out_ready);
    end

    assign bus.in_ready    = adv;
    assign bus.rom_clken   = adv;
    assign bus.rom_address = bus.in_k;
    assign bus.out_valid   = v4_q;
    assign bus.out_re      = out_q.re;
    assign bus.out_im      = out_q.im;

    always_comb begin
        a       = s2_q.re;
        b       = s2_q.im;
        wr      = tw2_q.wr;
        wi      = tw2_q.wi;
        p_awr_d = a * wr;
        p_bwi_d = b * wi;
        p_awi_d = a * wi;
        p_bwr_d = b * wr;
    end

    always_comb begin
        sum_re = p_awr_q - p_bwi_q;
        sum_im = p_awi_q + p_bwr_q;
    end

    bel_fft_round_sat u_round_re (
        .sum_i (sum_re),
        .res_o (res_re)
    );

    bel_fft_round_sat u_round_im (
        .sum_i (sum_im),
        .res_o (res_im)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            v3_q    <= 1'b0;
            v4_q    <= 1'b0;
            s1_q    <= '0;
            s2_q    <= '0;
            tw2_q   <= '0;
            p_awr_q <= '0;
            p_bwi_q <= '0;
            p_awi_q <= '0;
            p_bwr_q <= '0;
            out_q   <= '0;
        end else if (adv) begin
            // S1: the ROM samples in_k on this same edge, so its data lines up with S1.
            v1_q    <= bus.in_valid;
            s1_q    <= '{re: bus.in_re, im: bus.in_im};
            // S2: capture the ROM word alongside its sample.
            v2_q    <= v1_q;
            s2_q    <= s1_q;
            tw2_q   <= twiddle_t'(bus.rom_q);
            // S3
            v3_q    <= v2_q;
            p_awr_q <= p_awr_d;
            p_bwi_q <= p_bwi_d;
            p_awi_q <= p_awi_d;
            p_bwr_q <= p_bwr_d;
            // S4
            v4_q    <= v3_q;
            out_q   <= '{re: res_re, im: res_im};
        end
    end

endmodule

// File: tb/tb_bel_fft_twiddle_mult.sv
// Scoreboard bench for bel_fft_twiddle_mult: directed vectors, streaming, backpressure, reset.
module tb_bel_fft_twiddle_mult;
    import bel_fft_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bel_fft_twiddle_mult_if bus ();

    bel_fft_twiddle_mult dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    logic [63:0] rom [256];
    logic [63:0] exp_q [$];
    int          compared   = 0;
    int          mismatched = 0;
    logic        bp_mode    = 1'b0;

    // Twiddle ROM: 1-cycle registered read gated by clken.
    always @(posedge clk) begin
        if (bus.rom_clken) bus.rom_q <= rom[bus.rom_address];
    end

    initial begin : ready_driver
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.out_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        compared++;
        if (act !== expv) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    function automatic logic [31:0] sat32(input logic signed [127:0] v);
        logic signed [127:0] r;
        r = (v + 128'sd1073741824) >>> 31;
        if (r > 128'sd2147483647) return 32'h7FFF_FFFF;
        if (r < -128'sd2147483648) return 32'h8000_0000;
        return r[31:0];
    endfunction

    function automatic logic [63:0] golden(input logic [31:0] re, input logic [31:0] im,
                                           input logic [7:0] k);
        logic [63:0] w;
        longint      ar, ai, br, bi, wr, wi;
        w  = rom[k];
        ar = longint'($signed(re));
        br = longint'($signed(im));
        wr = longint'($signed(w[63:32]));
        wi = longint'($signed(w[31:0]));
        ai = ar * wi;
        bi = br * wi;
        ar = ar * wr;
        br = br * wr;
        return {sat32(128'(ar) - 128'(bi)), sat32(128'(ai) + 128'(br))};
    endfunction

    task automatic send(input logic [31:0] re, input logic [31:0] im, input logic [7:0] k,
                        input logic [63:0] expv);
        bit ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_re    = re;
        bus.in_im    = im;
        bus.in_k     = k;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                exp_q.push_back(expv);
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            compared++;
            mismatched++;
            $display("FAIL accept_timeout: got no in_ready, expected acceptance");
        end
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        logic        prev_stall = 1'b0;
        logic [63:0] prev_data  = '0;
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_valid", 64'(bus.out_valid), 64'd1);
                    check("stall_data", {bus.out_re, bus.out_im}, prev_data);
                end
                check("in_ready", 64'(bus.in_ready), 64'(!(bus.out_valid && !bus.out_ready)));
                check("rom_clken", 64'(bus.rom_clken), 64'(bus.in_ready));
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_out", 64'd1, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("result", {bus.out_re, bus.out_im}, e);
                    end
                end
                prev_stall = bus.out_valid && !bus.out_ready;
                prev_data  = {bus.out_re, bus.out_im};
            end
        end
    end

    initial begin : main
        real         pi;
        real         rc, rs;
        logic [31:0] re, im;
        bit          drained;

        pi = 3.14159265358979323846;
        for (int k = 0; k < 256; k++) begin
            rc = $cos(2.0 * pi * k / 256.0) * 2147483648.0;
            rs = -$sin(2.0 * pi * k / 256.0) * 2147483648.0;
            if (rc > 2147483647.0) rc = 2147483647.0;
            if (rc < -2147483647.0) rc = -2147483647.0;
            if (rs > 2147483647.0) rs = 2147483647.0;
            if (rs < -2147483647.0) rs = -2147483647.0;
            rom[k] = {32'($rtoi(rc)), 32'($rtoi(rs))};
        end
        rom[8'h00] = 64'h7FFF_FFFF_0000_0000;
        rom[8'h40] = 64'h0000_0000_8000_0001;
        rom[8'h60] = 64'hA57D_8667_A57D_8667;

        bus.in_valid = 1'b0;
        bus.in_re    = '0;
        bus.in_im    = '0;
        bus.in_k     = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        @(negedge clk);
        check("reset_out_valid", 64'(bus.out_valid), 64'd0);
        check("reset_out_data", {bus.out_re, bus.out_im}, 64'd0);
        check("reset_in_ready", 64'(bus.in_ready), 64'd1);
        check("reset_rom_clken", 64'(bus.rom_clken), 64'd1);
        @(posedge clk);
        #1;

        // Identity with latency check: result appears after the fourth edge.
        send(32'h4000_0000, 32'h0, 8'h00, 64'h4000_0000_0000_0000);
        bus.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("latency", 64'(bus.out_valid), 64'(i == 3));
        end
        @(posedge clk);
        #1;

        send(32'h4000_0000, 32'h0, 8'h40, 64'h0000_0000_C000_0001);
        send(32'h8000_0000, 32'h8000_0000, 8'h60, 64'h0000_0000_7FFF_FFFF);
        send(32'h4000_0000, 32'h0, 8'hFF, golden(32'h4000_0000, 32'h0, 8'hFF));
        bus.in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;

        // Back-to-back stream over every twiddle index.
        for (int k = 0; k < 256; k++) begin
            re = 32'h9E37_79B9 * 32'(k + 1);
            im = 32'h7F4A_7C15 * 32'(k + 3);
            send(re, im, 8'(k), golden(re, im, 8'(k)));
        end
        bus.in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;

        // Same stream under random backpressure.
        bp_mode = 1'b1;
        for (int k = 0; k < 256; k++) begin
            re = 32'h2545_F491 * 32'(k + 7) ^ 32'h8000_0000;
            im = 32'hC2B2_AE35 * 32'(k + 5);
            send(re, im, 8'(255 - k), golden(re, im, 8'(255 - k)));
        end
        bus.in_valid = 1'b0;
        bp_mode = 1'b0;
        drained = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(posedge clk);
            if (exp_q.size() == 0) begin
                drained = 1'b1;
                break;
            end
        end
        check("drain", 64'(drained), 64'd1);
        #1;

        // Reset with three samples in flight: they must vanish.
        send(32'h1111_1111, 32'h2222_2222, 8'h10, 64'h0);
        send(32'h3333_3333, 32'h4444_4444, 8'h20, 64'h0);
        send(32'h5555_5555, 32'h6666_6666, 8'h30, 64'h0);
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("reset_flush_valid", 64'(bus.out_valid), 64'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;

        send(32'h4000_0000, 32'h0, 8'h40, 64'h0000_0000_C000_0001);
        bus.in_valid = 1'b0;
        drained = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk);
            if (exp_q.size() == 0) begin
                drained = 1'b1;
                break;
            end
        end
        check("final_drain", 64'(drained), 64'd1);
        repeat (3) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
